// File: rtl/hazard_control_unit_pkg.sv
// Shared core constants for the hazard controller: register index width,
// the x0 index and the stall sequencing counter type.
package hazard_control_unit_pkg;
  localparam int CORE_REG_ADDR_W = 5;
  localparam logic [CORE_REG_ADDR_W-1:0] REG_X0 = '0;
  localparam int STALL_CNT_W = 2;
  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;
endpackage

// File: rtl/hazard_stat_counter.sv
// Saturating event counter; holds at all-ones once full.
module hazard_stat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (inc && count != '1) count <= count + {{(W-1){1'b0}}, 1'b1};
  end
endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / branch-dependency hazard controller with counter-sequenced stalls.
// Optional statistics counters under `HAZARD_STATS_EN.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_ADDR_W         = CORE_REG_ADDR_W,
  parameter int LOAD_BRANCH_STALLS = 2,
  parameter int STAT_W             = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] inst_rs1,
  input  logic [REG_ADDR_W-1:0] inst_rs2,
  input  logic                  inst_uses_rs1,
  input  logic                  inst_uses_rs2,
  input  logic                  inst_is_branch,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rd,
  input  logic                  ID_EX_regwrite,
  input  logic                  ID_EX_memread,
  input  logic                  branch_taken,
  input  logic                  ext_stall,
  output logic                  pc_write,
  output logic                  IF_ID_write,
  output logic                  ID_EX_bubble,
  output logic                  IF_ID_flush,
  output logic                  stall_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]     stall_count,
  output logic [STAT_W-1:0]     flush_count
`endif
);
  localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_X0);

  stall_cnt_t cnt, cnt_nxt;
  logic match1, match2, hit, det_en;
  logic ld_br, ld_use, alu_br, stall;

  assign match1 = inst_uses_rs1 && (inst_rs1 != X0) && (inst_rs1 == ID_EX_Rd);
  assign match2 = inst_uses_rs2 && (inst_rs2 != X0) && (inst_rs2 == ID_EX_Rd);
  assign hit    = match1 || match2;

  assign stall_busy = (cnt != '0);
  assign det_en     = !stall_busy && !ext_stall;
  assign ld_br      = ID_EX_memread && hit && inst_is_branch;
  assign ld_use     = ID_EX_memread && hit;
  assign alu_br     = inst_is_branch && ID_EX_regwrite && hit;
  // Remaining counted cycles stall without re-running detection.
  assign stall      = !ext_stall && (stall_busy || (det_en && (ld_use || alu_br)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  always_comb begin
    cnt_nxt = cnt;
    if (!ext_stall) begin
      if (stall_busy) cnt_nxt = cnt - stall_cnt_t'(1);
      else if (ld_br) cnt_nxt = stall_cnt_t'(LOAD_BRANCH_STALLS - 1);
      else            cnt_nxt = '0;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b1;
    end else if (ext_stall) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
    end else if (stall) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end else begin
      IF_ID_flush = inst_is_branch && branch_taken;
    end
  end

`ifdef HAZARD_STATS_EN
  hazard_stat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(ID_EX_bubble), .count(stall_count)
  );
  hazard_stat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(IF_ID_flush), .count(flush_count)
  );
`endif
endmodule
